register_file: RTL and testbench

- 8-bit registered ALU stage that sits between the operand source and the write-back path.
- Each clock it computes ADD/SUB/AND/OR of two 8-bit operands, selected by a 2-bit opcode.
- It registers the result, a copy of operand 1, and the carry and signed-overflow flags.
- Combinational datapath is a separate ALU sub-module; this block owns the state.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu8.sv | 47 ++++
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU stage: opcode encodings and default width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

endpackage

// File: rtl/alu8.sv
// Combinational ALU datapath: ADD/SUB/AND/OR with unsigned carry and signed overflow flags.
module alu8
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    // SUB as A + ~B + 1 so that carry out reads as "no borrow".
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        y        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                y        = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y        = dif[WIDTH-1:0];
                carry    = dif[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            default: begin
                y        = '0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Registered ALU stage: one-cycle latency result, operand-1 copy and flags, synchronous reset.
module register_file
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inreg1,
    input  logic [WIDTH-1:0] inreg2,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] store_word,
    output logic [WIDTH-1:0] store_inp1,
    output logic             carry_output,
    output logic             overflow_output
);

    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;

    alu8 #(.WIDTH(WIDTH)) u_alu (
        .a        (inreg1),
        .b        (inreg2),
        .op       (opcode),
        .y        (alu_y),
        .carry    (alu_c),
        .overflow (alu_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            store_word      <= '0;
            store_inp1      <= '0;
            carry_output    <= 1'b0;
            overflow_output <= 1'b0;
        end else begin
            store_word      <= alu_y;
            store_inp1      <= inreg1;
            carry_output    <= alu_c;
            overflow_output <= alu_v;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expected outputs queued at drive time, popped after each edge.
module tb_register_file;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inreg1;
    logic [7:0] inreg2;
    logic [1:0] opcode;
    logic [7:0] store_word;
    logic [7:0] store_inp1;
    logic       carry_output;
    logic       overflow_output;

    typedef struct {
        logic [7:0] word;
        logic [7:0] inp1;
        logic       c;
        logic       v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    register_file #(.WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .inreg1          (inreg1),
        .inreg2          (inreg2),
        .opcode          (opcode),
        .store_word      (store_word),
        .store_inp1      (store_inp1),
        .carry_output    (carry_output),
        .overflow_output (overflow_output)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.tag, ".word"}, store_word, e.word);
        chk({e.tag, ".inp1"}, store_inp1, e.inp1);
        chk({e.tag, ".c"}, {7'd0, carry_output}, {7'd0, e.c});
        chk({e.tag, ".v"}, {7'd0, overflow_output}, {7'd0, e.v});
    endtask

    task automatic pop_check();
        exp_t e;
        n_chk++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty expected entry");
            return;
        end
        e = sb.pop_front();
        chk_all(e);
    endtask

    // Drive away from the edge, queue the expectation, check just after the capturing edge.
    task automatic step(input string tag, input logic r, input logic [7:0] a, input logic [7:0] b,
                        input op_e op, input logic [7:0] ew, input logic [7:0] ei,
                        input logic ec, input logic ev);
        exp_t e;
        @(negedge clk);
        rst    = r;
        inreg1 = a;
        inreg2 = b;
        opcode = op;
        e.word = ew; e.inp1 = ei; e.c = ec; e.v = ev; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        exp_t hold;
        rst = 1'b1; inreg1 = 8'h55; inreg2 = 8'hAA; opcode = OP_ADD;

        step("rst0", 1'b1, 8'h55, 8'hAA, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        step("rst1", 1'b1, 8'h55, 8'hAA, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        step("first", 1'b0, 8'h55, 8'hAA, OP_ADD, 8'hFF, 8'h55, 1'b0, 1'b0);

        step("one_add", 1'b0, 8'h01, 8'h01, OP_ADD, 8'h02, 8'h01, 1'b0, 1'b0);
        step("one_sub", 1'b0, 8'h01, 8'h01, OP_SUB, 8'h00, 8'h01, 1'b1, 1'b0);
        step("one_and", 1'b0, 8'h01, 8'h01, OP_AND, 8'h01, 8'h01, 1'b0, 1'b0);
        step("one_or",  1'b0, 8'h01, 8'h01, OP_OR,  8'h01, 8'h01, 1'b0, 1'b0);

        step("p127_add", 1'b0, 8'd127, 8'd10, OP_ADD, 8'h89, 8'h7F, 1'b0, 1'b1);
        step("p127_sub", 1'b0, 8'd127, 8'd10, OP_SUB, 8'h75, 8'h7F, 1'b1, 1'b0);
        step("p127_and", 1'b0, 8'd127, 8'd10, OP_AND, 8'h0A, 8'h7F, 1'b0, 1'b0);
        step("p127_or",  1'b0, 8'd127, 8'd10, OP_OR,  8'h7F, 8'h7F, 1'b0, 1'b0);

        step("neg_add", 1'b0, 8'd12, 8'hF6, OP_ADD, 8'h02, 8'h0C, 1'b1, 1'b0);
        step("neg_sub", 1'b0, 8'd12, 8'hF6, OP_SUB, 8'h16, 8'h0C, 1'b0, 1'b0);
        step("neg_and", 1'b0, 8'd12, 8'hF6, OP_AND, 8'h04, 8'h0C, 1'b0, 1'b0);
        step("neg_or",  1'b0, 8'd12, 8'hF6, OP_OR,  8'hFE, 8'h0C, 1'b0, 1'b0);

        step("min_sub1", 1'b0, 8'h80, 8'h01, OP_SUB, 8'h7F, 8'h80, 1'b1, 1'b1);
        step("ff_add1",  1'b0, 8'hFF, 8'h01, OP_ADD, 8'h00, 8'hFF, 1'b1, 1'b0);
        step("min_min",  1'b0, 8'h80, 8'h80, OP_ADD, 8'h00, 8'h80, 1'b1, 1'b1);

        // Mid-cycle input change must not disturb the held outputs.
        step("pre_mid", 1'b0, 8'h10, 8'h20, OP_ADD, 8'h30, 8'h10, 1'b0, 1'b0);
        #2;
        inreg1 = 8'h40; inreg2 = 8'h01; opcode = OP_SUB;
        #1;
        hold.word = 8'h30; hold.inp1 = 8'h10; hold.c = 1'b0; hold.v = 1'b0; hold.tag = "hold";
        chk_all(hold);
        hold.word = 8'h3F; hold.inp1 = 8'h40; hold.c = 1'b1; hold.v = 1'b0; hold.tag = "mid_new";
        sb.push_back(hold);
        @(posedge clk);
        #1;
        pop_check();

        step("mid_rst",  1'b1, 8'hC3, 8'h3C, OP_OR, 8'h00, 8'h00, 1'b0, 1'b0);
        step("post_rst", 1'b0, 8'hC3, 8'h3C, OP_OR, 8'hFF, 8'hC3, 1'b0, 1'b0);

        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
